// File: rtl/cmd_pkg.sv
// Shared definitions for the command sequencer.
// Opcodes, FSM states and default widths.
package cmd_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 3;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_MOVI = 2'b10,
      OP_READ = 2'b11
   } opcode_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_EXEC  = 3'd1,
      ST_SEND  = 3'd2,
      ST_GUARD = 3'd3,
      ST_DRAIN = 3'd4
   } state_t;

endpackage

// File: rtl/cmd_regfile.sv
// Register file: two async read ports, one sync write port,
// asynchronous active-low clear.
module cmd_regfile
   import cmd_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2
);

   localparam int N = 2**ADDR_W;

   logic [DATA_W-1:0] mem_q [N];
   logic [DATA_W-1:0] mem_d [N];

   // Next register contents: apply the single write.
   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[waddr] = wdata;
   end

   // Register storage with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) mem_q[i] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata1 = mem_q[raddr1];
   assign rdata2 = mem_q[raddr2];

endmodule

// File: rtl/cmd_sequencer.sv
// Command sequencer: executes decoded register commands
// and hands the response byte to a UART transmitter.
module cmd_sequencer
   import cmd_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   input  logic [1:0]        opcode,
   input  logic [ADDR_W-1:0] operand1,
   input  logic [ADDR_W-1:0] operand2,
   output logic              cmd_ack,
   input  logic              tx_busy,
   output logic              tx_start,
   output logic [DATA_W-1:0] tx_data,
   output logic              busy,
   output logic              flag_c,
   output logic [7:0]        cmd_count
);

   state_t            state_q, state_d;
   opcode_t           op_q, op_d;
   logic [ADDR_W-1:0] a1_q, a1_d;
   logic [ADDR_W-1:0] a2_q, a2_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic              flag_q, flag_d;
   logic [7:0]        count_q, count_d;

   logic              we;
   logic [DATA_W-1:0] rd1, rd2;
   logic [DATA_W-1:0] exec_val;
   logic [DATA_W:0]   sum_w;
   logic [DATA_W-1:0] imm;

   cmd_regfile #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_regfile (
      .clk    (clk),
      .rst_n  (reset),
      .we     (we),
      .waddr  (a1_q),
      .wdata  (exec_val),
      .raddr1 (a1_q),
      .rdata1 (rd1),
      .raddr2 (a2_q),
      .rdata2 (rd2)
   );

   assign sum_w = {1'b0, rd1} + {1'b0, rd2};
   assign imm   = {{(DATA_W-ADDR_W){1'b0}}, a2_q};

   // Value written back and reported for the latched command.
   always_comb begin
      exec_val = rd1;
      unique case (op_q)
         OP_ADD:  exec_val = sum_w[DATA_W-1:0];
         OP_SUB:  exec_val = rd1 - rd2;
         OP_MOVI: exec_val = imm;
         OP_READ: exec_val = rd1;
      endcase
   end

   // Next-state, datapath updates and FSM outputs.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a1_d      = a1_q;
      a2_d      = a2_q;
      result_d  = result_q;
      tx_data_d = tx_data_q;
      flag_d    = flag_q;
      count_d   = count_q;
      we        = 1'b0;
      cmd_ack   = 1'b0;
      tx_start  = 1'b0;
      busy      = 1'b1;
      unique case (state_q)
         ST_IDLE: begin
            busy = 1'b0;
            if (cmd_valid) begin
               op_d    = opcode_t'(opcode);
               a1_d    = operand1;
               a2_d    = operand2;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            cmd_ack  = 1'b1;
            result_d = exec_val;
            we       = (op_q != OP_READ);
            if (op_q == OP_ADD) flag_d = sum_w[DATA_W];
            if (op_q == OP_SUB) flag_d = (rd1 < rd2);
            state_d  = ST_SEND;
         end
         ST_SEND: begin
            if (!tx_busy) begin
               tx_data_d = result_q;
               state_d   = ST_GUARD;
            end
         end
         ST_GUARD: begin
            tx_start = 1'b1;
            state_d  = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!tx_busy) begin
               count_d = count_q + 8'd1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_ADD;
         a1_q      <= '0;
         a2_q      <= '0;
         result_q  <= '0;
         tx_data_q <= '0;
         flag_q    <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a1_q      <= a1_d;
         a2_q      <= a2_d;
         result_q  <= result_d;
         tx_data_q <= tx_data_d;
         flag_q    <= flag_d;
         count_q   <= count_d;
      end
   end

   assign tx_data   = tx_data_q;
   assign flag_c    = flag_q;
   assign cmd_count = count_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed self-checking bench for cmd_sequencer.
// Table of commands plus hand sequences for stall/reset.
module tb_cmd_sequencer;

   logic       clk;
   logic       reset;
   logic       cmd_valid;
   logic [1:0] opcode;
   logic [2:0] operand1;
   logic [2:0] operand2;
   logic       cmd_ack;
   logic       tx_busy;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       busy;
   logic       flag_c;
   logic [7:0] cmd_count;

   int checks = 0;
   int errors = 0;

   cmd_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .opcode    (opcode),
      .operand1  (operand1),
      .operand2  (operand2),
      .cmd_ack   (cmd_ack),
      .tx_busy   (tx_busy),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .busy      (busy),
      .flag_c    (flag_c),
      .cmd_count (cmd_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] op;
      logic [2:0] a1;
      logic [2:0] a2;
      logic [7:0] d;
      logic       f;
   } vec_t;

   vec_t tbl[14];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h",
                  name, act, exp);
      end
   endtask

   task automatic do_cmd(input logic [1:0] op,
                         input logic [2:0] a1,
                         input logic [2:0] a2,
                         input logic [7:0] d,
                         input logic       f,
                         input logic [7:0] cnt);
      cmd_valid = 1'b1;
      opcode    = op;
      operand1  = a1;
      operand2  = a2;
      step();
      chk("ack", cmd_ack, 1);
      chk("busy_exec", busy, 1);
      cmd_valid = 1'b0;
      step();
      chk("send_no_start", tx_start, 0);
      chk("send_no_ack", cmd_ack, 0);
      step();
      chk("tx_start", tx_start, 1);
      chk("tx_data", tx_data, d);
      step();
      chk("guard_end", tx_start, 0);
      chk("tx_data_hold", tx_data, d);
      step();
      chk("idle", busy, 0);
      chk("flag_c", flag_c, f);
      chk("cmd_count", cmd_count, cnt);
   endtask

   initial begin
      tbl[0]  = '{2'b10, 3'd5, 3'd2, 8'h02, 1'b0};
      tbl[1]  = '{2'b10, 3'd1, 3'd7, 8'h07, 1'b0};
      tbl[2]  = '{2'b00, 3'd1, 3'd1, 8'h0E, 1'b0};
      tbl[3]  = '{2'b00, 3'd1, 3'd1, 8'h1C, 1'b0};
      tbl[4]  = '{2'b00, 3'd1, 3'd1, 8'h38, 1'b0};
      tbl[5]  = '{2'b00, 3'd1, 3'd1, 8'h70, 1'b0};
      tbl[6]  = '{2'b00, 3'd1, 3'd1, 8'hE0, 1'b0};
      tbl[7]  = '{2'b00, 3'd1, 3'd1, 8'hC0, 1'b1};
      tbl[8]  = '{2'b11, 3'd1, 3'd0, 8'hC0, 1'b1};
      tbl[9]  = '{2'b10, 3'd4, 3'd3, 8'h03, 1'b1};
      tbl[10] = '{2'b01, 3'd3, 3'd4, 8'hFD, 1'b1};
      tbl[11] = '{2'b11, 3'd3, 3'd0, 8'hFD, 1'b1};
      tbl[12] = '{2'b01, 3'd1, 3'd1, 8'h00, 1'b0};
      tbl[13] = '{2'b00, 3'd4, 3'd5, 8'h05, 1'b0};

      reset     = 1'b0;
      cmd_valid = 1'b0;
      opcode    = 2'b00;
      operand1  = 3'd0;
      operand2  = 3'd0;
      tx_busy   = 1'b0;
      step();
      step();
      chk("rst_busy", busy, 0);
      chk("rst_ack", cmd_ack, 0);
      chk("rst_start", tx_start, 0);
      chk("rst_data", tx_data, 0);
      chk("rst_flag", flag_c, 0);
      chk("rst_count", cmd_count, 0);
      reset = 1'b1;

      for (int i = 0; i < 14; i++) begin
         do_cmd(tbl[i].op, tbl[i].a1, tbl[i].a2,
                tbl[i].d, tbl[i].f, 8'(i + 1));
      end

      // Transmitter stall with a second command pending.
      cmd_valid = 1'b1;
      opcode    = 2'b11;
      operand1  = 3'd4;
      operand2  = 3'd0;
      step();
      chk("stall_ack", cmd_ack, 1);
      opcode   = 2'b10;
      operand1 = 3'd6;
      operand2 = 3'd5;
      tx_busy  = 1'b1;
      step();
      for (int i = 0; i < 10; i++) begin
         step();
         chk("stall_no_start", tx_start, 0);
         chk("stall_no_ack", cmd_ack, 0);
      end
      tx_busy = 1'b0;
      step();
      chk("stall_start", tx_start, 1);
      chk("stall_data", tx_data, 8'h05);
      tx_busy = 1'b1;
      step();
      chk("guard_ign_busy", busy, 1);
      chk("guard_end2", tx_start, 0);
      step();
      chk("drain_hold", busy, 1);
      chk("drain_no_ack", cmd_ack, 0);
      chk("drain_count", cmd_count, 14);
      tx_busy = 1'b0;
      step();
      chk("drain_idle", busy, 0);
      chk("drain_no_ack2", cmd_ack, 0);
      chk("drain_count2", cmd_count, 15);
      step();
      chk("pending_ack", cmd_ack, 1);
      cmd_valid = 1'b0;
      step();
      step();
      chk("pending_start", tx_start, 1);
      chk("pending_data", tx_data, 8'h05);
      step();
      step();
      chk("pending_idle", busy, 0);
      chk("pending_count", cmd_count, 16);

      do_cmd(2'b01, 3'd7, 3'd6, 8'hFB, 1'b1, 8'd17);

      // Reset while draining aborts the command.
      cmd_valid = 1'b1;
      opcode    = 2'b11;
      operand1  = 3'd5;
      operand2  = 3'd0;
      step();
      chk("abort_ack", cmd_ack, 1);
      cmd_valid = 1'b0;
      step();
      step();
      chk("abort_start", tx_start, 1);
      chk("abort_data", tx_data, 8'h02);
      tx_busy = 1'b1;
      step();
      step();
      chk("abort_drain", busy, 1);
      reset = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_tx_start", tx_start, 0);
      chk("abort_ack0", cmd_ack, 0);
      chk("abort_flag", flag_c, 0);
      chk("abort_tx_data", tx_data, 0);
      chk("abort_count", cmd_count, 0);
      step();
      tx_busy = 1'b0;
      reset   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("post_rst_start", tx_start, 0);
         chk("post_rst_busy", busy, 0);
      end
      chk("post_rst_count", cmd_count, 0);
      do_cmd(2'b11, 3'd5, 3'd0, 8'h00, 1'b0, 8'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
